hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 75 +++++++
 tb/tb_hazard_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: rs/rt load-use interlock plus multiply/divide busy interlock.
// Latency: stall is combinational (zero cycles); md_busy and stall_cnt are registered on clk.
// Backpressure: stall freezes PC and F/D and bubbles D/E; nothing here is ever held off.
// Optional build macro HAZARD_STALL_STATS_EN enables the stall_cnt counter (otherwise tied to 0).
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        md_D,
  input  logic [4:0]  a_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  a_M,
  input  logic [1:0]  tnew_M,
  input  logic        md_start_E,
  input  logic        md_div_E,
  output logic        stall,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  logic [3:0] md_cnt;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;

  assign md_busy = (md_cnt != 4'd0);

  // Busy window: a new start always reloads, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= 4'd0;
    end else if (md_start_E) begin
      md_cnt <= md_div_E ? DIV_CYCLES : MULT_CYCLES;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  // Interlock decision: a source operand stalls when a producer in E or M cannot
  // deliver it in time; register 0 is hardwired and never creates a dependency.
  always_comb begin
    stall_rs = (rs_D != 5'd0) &&
               (((rs_D == a_E) && (tuse_rs_D < tnew_E)) ||
                ((rs_D == a_M) && (tuse_rs_D < tnew_M)));
    stall_rt = (rt_D != 5'd0) &&
               (((rt_D == a_E) && (tuse_rt_D < tnew_E)) ||
                ((rt_D == a_M) && (tuse_rt_D < tnew_M)));
    stall_md = md_D && (md_start_E || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cnt_q;

  // Stall statistics: one count per stalled cycle, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expectation queue per step.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs_D = '0;
  logic [4:0]  rt_D = '0;
  logic [1:0]  tuse_rs_D = 2'd3;
  logic [1:0]  tuse_rt_D = 2'd3;
  logic        md_D = 1'b0;
  logic [4:0]  a_E = '0;
  logic [1:0]  tnew_E = '0;
  logic [4:0]  a_M = '0;
  logic [1:0]  tnew_M = '0;
  logic        md_start_E = 1'b0;
  logic        md_div_E = 1'b0;
  logic        stall;
  logic        md_busy;
  logic [31:0] stall_cnt;

  typedef struct {
    string       tag;
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] exp_cnt = 32'd0;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .tuse_rs_D  (tuse_rs_D),
    .tuse_rt_D  (tuse_rt_D),
    .md_D       (md_D),
    .a_E        (a_E),
    .tnew_E     (tnew_E),
    .a_M        (a_M),
    .tnew_M     (tnew_M),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .stall      (stall),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, queue the expectation, then
  // compare shortly afterwards while inputs are stable and before the next rising edge.
  task automatic apply(input string tag,
                       input logic [4:0] rs, input logic [1:0] tur,
                       input logic [4:0] rt, input logic [1:0] tut,
                       input logic md,
                       input logic [4:0] ae, input logic [1:0] te,
                       input logic [4:0] am, input logic [1:0] tm,
                       input logic st, input logic dv, input logic rst,
                       input logic es, input logic eb);
    exp_t e;
    @(negedge clk);
    rs_D = rs; tuse_rs_D = tur; rt_D = rt; tuse_rt_D = tut; md_D = md;
    a_E = ae; tnew_E = te; a_M = am; tnew_M = tm;
    md_start_E = st; md_div_E = dv; reset = rst;
`ifdef HAZARD_STALL_STATS_EN
    sb.push_back('{tag, es, eb, exp_cnt});
`else
    sb.push_back('{tag, es, eb, 32'd0});
`endif
    #1;
    e = sb.pop_front();
    n_total++;
    assert (stall === e.stall) n_pass++;
      else $error("FAIL %s.stall observed=%b expected=%b", e.tag, stall, e.stall);
    n_total++;
    assert (md_busy === e.busy) n_pass++;
      else $error("FAIL %s.md_busy observed=%b expected=%b", e.tag, md_busy, e.busy);
    n_total++;
    assert (stall_cnt === e.cnt) n_pass++;
      else $error("FAIL %s.stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.cnt);
    // Counter expectation for the next step follows this step's edge.
    if (rst) exp_cnt = 32'd0;
    else if (es) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    // Reset, including a multiply start that must be overridden by reset.
    apply("rst0",     0,3, 0,3, 0,  0,0, 0,0, 0,0,1, 0,0);
    apply("rst_ovr",  0,3, 0,3, 0,  0,0, 0,0, 1,0,1, 0,0);
    apply("idle",     0,3, 0,3, 0,  0,0, 0,0, 0,0,0, 0,0);

    // Operand hazards.
    apply("rs_E",     8,0, 0,3, 0,  8,1, 0,0, 0,0,0, 1,0);
    apply("rs_M_ok",  8,0, 0,3, 0,  0,0, 8,0, 0,0,0, 0,0);
    apply("r0_E",     0,0, 0,3, 0,  0,2, 0,0, 0,0,0, 0,0);
    apply("rs_eq",    8,1, 0,3, 0,  8,1, 0,0, 0,0,0, 0,0);
    apply("rs_M",     9,0, 0,3, 0,  0,0, 9,1, 0,0,0, 1,0);
    apply("rt_E",     0,3, 12,1, 0, 12,2, 0,0, 0,0,0, 1,0);
    apply("rt_never", 0,3, 12,3, 0, 12,2, 0,0, 0,0,0, 0,0);
    apply("both_M",   5,1, 0,3, 0,  5,1, 5,2, 0,0,0, 1,0);
    apply("both_E",   5,0, 0,3, 0,  5,2, 5,0, 0,0,0, 1,0);
    apply("r0_M",     0,3, 0,0, 0,  0,0, 0,2, 0,0,0, 0,0);
    apply("other",    3,0, 0,3, 0,  4,2, 4,2, 0,0,0, 0,0);
    apply("rt_Mb",    0,3, 7,0, 0,  0,0, 7,3, 0,0,0, 1,0);
    apply("rs_Eb",    6,1, 0,3, 0,  6,3, 0,0, 0,0,0, 1,0);
    apply("rt_Ec",    0,3, 2,2, 0,  2,3, 0,0, 0,0,0, 1,0);

    // Multiply window with a waiting md instruction: stall on start plus 5 busy cycles.
    apply("mul_st",   0,3, 0,3, 1,  0,0, 0,0, 1,0,0, 1,0);
    for (int i = 0; i < 5; i++)
      apply("mul_busy", 0,3, 0,3, 1, 0,0, 0,0, 0,0,0, 1,1);
    apply("mul_done", 0,3, 0,3, 1,  0,0, 0,0, 0,0,0, 0,0);

    // Restart at md_cnt=2 reloads the full multiply window.
    apply("rl_st",    0,3, 0,3, 0,  0,0, 0,0, 1,0,0, 0,0);
    for (int i = 0; i < 3; i++)
      apply("rl_busy", 0,3, 0,3, 0, 0,0, 0,0, 0,0,0, 0,1);
    apply("rl_again", 0,3, 0,3, 0,  0,0, 0,0, 1,0,0, 0,1);
    for (int i = 0; i < 5; i++)
      apply("rl_win",  0,3, 0,3, 0, 0,0, 0,0, 0,0,0, 0,1);
    apply("rl_done",  0,3, 0,3, 0,  0,0, 0,0, 0,0,0, 0,0);

    // Divide aborted by reset three cycles after start.
    apply("dv_st",    0,3, 0,3, 1,  0,0, 0,0, 1,1,0, 1,0);
    apply("dv_b1",    0,3, 0,3, 1,  0,0, 0,0, 0,0,0, 1,1);
    apply("dv_b2",    0,3, 0,3, 1,  0,0, 0,0, 0,0,0, 1,1);
    apply("dv_rst",   0,3, 0,3, 1,  0,0, 0,0, 0,0,1, 1,1);
    apply("dv_abort", 0,3, 0,3, 1,  0,0, 0,0, 0,0,0, 0,0);

    // Full divide window is 10 cycles.
    apply("dv2_st",   0,3, 0,3, 0,  0,0, 0,0, 1,1,0, 0,0);
    for (int i = 0; i < 10; i++)
      apply("dv2_busy", 0,3, 0,3, 1, 0,0, 0,0, 0,0,0, 1,1);
    apply("dv2_done", 0,3, 0,3, 1,  0,0, 0,0, 0,0,0, 0,0);

    // Seven stalls straight after a reset, then a quiet cycle to observe the count.
    apply("st_rst",   0,3, 0,3, 0,  0,0, 0,0, 0,0,1, 0,0);
    for (int i = 0; i < 7; i++)
      apply("st7",    8,0, 0,3, 0,  8,1, 0,0, 0,0,0, 1,0);
    apply("st7_end",  0,3, 0,3, 0,  0,0, 0,0, 0,0,0, 0,0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
